// File: rtl/lsu_requester.sv
// Load/store requester: decodes funct3, checks legality, issues one data-memory request, returns an extended load result.
// Latency: store 2 cycles and load 3 cycles from the start edge with no wait states; early faults and no-ops finish in 1 cycle.
// Backpressure: waits in REQ on mem_req_ready and in RSP on mem_rsp_valid, bounded by TIMEOUT_CYCLES; start is ignored while busy.
module lsu_requester #(
    parameter int MEM_BYTES      = 8192,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int AW            = $clog2(MEM_BYTES) - 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          is_load,
    input  logic          is_store,
    input  logic [2:0]    funct3,
    input  logic [63:0]   addr,
    input  logic [63:0]   store_data,
    output logic          busy,
    output logic          done,
    output logic [63:0]   load_data,
    output logic          fault,
    output logic [1:0]    fault_cause,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_we,
    output logic [AW-1:0] mem_req_addr,
    output logic [63:0]   mem_req_wdata,
    output logic [7:0]    mem_req_wstrb,
    input  logic          mem_rsp_valid,
    input  logic [63:0]   mem_rsp_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    op_funct3;
    logic [2:0]    op_off;

    logic          is_access;
    logic          bad_op;
    logic          bad_align;
    logic          bad_range;
    logic [7:0]    lane_mask;
    logic [7:0]    wstrb_nxt;
    logic [63:0]   wdata_nxt;
    logic          timed_out;

    // Extract the addressed bytes of a read word and extend them to 64 bits.
    function automatic logic [63:0] extract(input logic [63:0] rdata,
                                            input logic [2:0]  off,
                                            input logic [2:0]  f3);
        logic [63:0] r;
        r = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  extract = {{56{r[7]}},  r[7:0]};
            3'b001:  extract = {{48{r[15]}}, r[15:0]};
            3'b010:  extract = {{32{r[31]}}, r[31:0]};
            3'b011:  extract = r;
            3'b100:  extract = {56'd0, r[7:0]};
            3'b101:  extract = {48'd0, r[15:0]};
            3'b110:  extract = {32'd0, r[31:0]};
            default: extract = 64'd0;
        endcase
    endfunction

    // Decode the operation presented with start: legality, alignment, range and lane placement.
    always_comb begin
        is_access = is_load | is_store;
        bad_op    = (is_load & is_store) |
                    (is_load & (funct3 == 3'b111)) |
                    (is_store & funct3[2]);
        bad_align = 1'b0;
        lane_mask = 8'h01;
        case (funct3[1:0])
            2'b00: begin lane_mask = 8'h01; bad_align = 1'b0;              end
            2'b01: begin lane_mask = 8'h03; bad_align = addr[0];           end
            2'b10: begin lane_mask = 8'h0F; bad_align = |addr[1:0];        end
            2'b11: begin lane_mask = 8'hFF; bad_align = |addr[2:0];        end
            default: begin lane_mask = 8'h01; bad_align = 1'b0;            end
        endcase
        // Alignment and range only matter when an access is actually made.
        bad_align = bad_align & is_access;
        bad_range = is_access & (addr >= 64'(MEM_BYTES));
        wstrb_nxt = lane_mask << addr[2:0];
        wdata_nxt = store_data << {addr[2:0], 3'b000};
    end

    // The last permitted REQ/RSP cycle; a completion in that cycle still wins.
    always_comb begin
        timed_out = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    end

    // Request sequencer: single FSM owning every registered output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            op_funct3     <= 3'd0;
            op_off        <= 3'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            load_data     <= 64'd0;
            fault         <= 1'b0;
            fault_cause   <= 2'b00;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= 64'd0;
            mem_req_wstrb <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_funct3   <= funct3;
                        op_off      <= addr[2:0];
                        busy        <= 1'b1;
                        load_data   <= 64'd0;
                        fault       <= 1'b0;
                        fault_cause <= 2'b00;
                        if (bad_op) begin
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_ILLEGAL;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else if (bad_align) begin
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGN;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else if (bad_range) begin
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_RANGE;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else if (!is_access) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= is_store;
                            mem_req_addr  <= addr[AW+2:3];
                            mem_req_wdata <= wdata_nxt;
                            mem_req_wstrb <= wstrb_nxt;
                            wait_cnt      <= '0;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    // A store finishes on acceptance; a load still needs its response.
                    if (mem_req_ready && mem_req_we) begin
                        mem_req_valid <= 1'b0;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else if (timed_out) begin
                        mem_req_valid <= 1'b0;
                        fault         <= 1'b1;
                        fault_cause   <= CAUSE_TIMEOUT;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (mem_req_ready) begin
                            mem_req_valid <= 1'b0;
                            state         <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (mem_rsp_valid) begin
                        load_data <= extract(mem_rsp_rdata, op_off, op_funct3);
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (timed_out) begin
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy          <= 1'b0;
                    mem_req_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_requester.sv
module tb_lsu_requester;

    localparam int MEM_BYTES = 8192;
    localparam int TMO       = 16;
    localparam int AW        = $clog2(MEM_BYTES) - 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          is_load;
    logic          is_store;
    logic [2:0]    funct3;
    logic [63:0]   addr;
    logic [63:0]   store_data;
    logic          busy;
    logic          done;
    logic [63:0]   load_data;
    logic          fault;
    logic [1:0]    fault_cause;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [63:0]   mem_req_wdata;
    logic [7:0]    mem_req_wstrb;
    logic          mem_rsp_valid;
    logic [63:0]   mem_rsp_rdata;

    always #5 clk = ~clk;

    lsu_requester #(.MEM_BYTES(MEM_BYTES), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .fault(fault), .fault_cause(fault_cause),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    // Outcome of one operation, as observed or as expected.
    typedef struct {
        int            cyc;
        logic          flt;
        logic [1:0]    cause;
        logic [63:0]   ld;
        logic          vld;
        logic          unstable;
        logic          we;
        logic [AW-1:0] raddr;
        logic [63:0]   wdata;
        logic [7:0]    strb;
        logic          ibusy;
        logic          iflt;
        logic [63:0]   ild;
    } obs_t;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] sd;
        logic [63:0] rd;
        int          rdy;
        int          rsp;
        obs_t        e;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rd,
                                input int rdy, input int rsp, input int cyc,
                                input logic flt, input logic [1:0] cause, input logic [63:0] eld,
                                input logic vld, input logic we, input logic [63:0] raddr,
                                input logic [63:0] wd, input logic [7:0] strb);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.sd = sd; v.rd = rd; v.rdy = rdy; v.rsp = rsp;
        v.e = '{default: 0};
        v.e.cyc = cyc; v.e.flt = flt; v.e.cause = cause; v.e.ld = eld; v.e.vld = vld;
        v.e.we = we; v.e.raddr = raddr[AW-1:0]; v.e.wdata = wd; v.e.strb = strb;
        tbl.push_back(v);
    endfunction

    // Reference model: outcome straight from the access rules and the wait-state budget.
    function automatic obs_t model(input vec_t v);
        obs_t        e;
        int          bytes;
        int          off;
        int          used;
        logic [63:0] m;
        logic [63:0] r;
        e = '{default: 0};
        bytes = 1 << v.f3[1:0];
        off   = int'(v.a % 64'd8);
        e.cyc = 1;
        if ((v.ld && v.st) || (v.ld && v.f3 == 3'd7) || (v.st && v.f3 >= 3'd4)) begin
            e.flt = 1'b1; e.cause = 2'd0; return e;
        end
        if (!v.ld && !v.st) return e;
        if (v.a % 64'(bytes) != 64'd0) begin e.flt = 1'b1; e.cause = 2'd1; return e; end
        if (v.a >= 64'(MEM_BYTES))     begin e.flt = 1'b1; e.cause = 2'd2; return e; end
        e.vld   = 1'b1;
        e.we    = v.st;
        e.raddr = AW'(v.a / 64'd8);
        e.strb  = 8'(((1 << bytes) - 1) << off);
        e.wdata = v.sd << (8 * off);
        used = v.st ? v.rdy + 1 : v.rdy + v.rsp + 2;
        if (used > TMO) begin
            e.cyc = TMO + 1; e.flt = 1'b1; e.cause = 2'd3; return e;
        end
        e.cyc = used + 1;
        if (v.ld) begin
            r = v.rd >> (8 * off);
            if (bytes < 8) begin
                m = (64'd1 << (8 * bytes)) - 64'd1;
                r = r & m;
                if (!v.f3[2] && r[8 * bytes - 1]) r = r | ~m;
            end
            e.ld = r;
        end
        return e;
    endfunction

    // Drive one operation from a negedge, play the memory side with the requested wait states.
    task automatic run_op(input vec_t v, output obs_t o);
        logic first;
        logic hs;
        int   qw;
        int   rw;
        o = '{default: 0};
        is_load = v.ld; is_store = v.st; funct3 = v.f3; addr = v.a; store_data = v.sd;
        mem_rsp_rdata = v.rd; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        start = 1'b1;
        first = 1'b1; hs = 1'b0; qw = 0; rw = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (done) begin
                o.cyc = c; o.flt = fault; o.cause = fault_cause; o.ld = load_data;
                break;
            end
            if (mem_req_valid) begin
                if (first) begin
                    o.vld = 1'b1; o.we = mem_req_we; o.raddr = mem_req_addr;
                    o.wdata = mem_req_wdata; o.strb = mem_req_wstrb; first = 1'b0;
                end else if (o.we != mem_req_we || o.raddr != mem_req_addr ||
                             o.wdata != mem_req_wdata || o.strb != mem_req_wstrb) begin
                    o.unstable = 1'b1;
                end
                if (qw >= v.rdy) begin mem_req_ready = 1'b1; hs = 1'b1; end
                qw++;
            end else if (hs && v.ld) begin
                if (rw >= v.rsp) mem_rsp_valid = 1'b1;
                rw++;
            end
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        o.ibusy = busy | done;
        o.iflt  = fault;
        o.ild   = load_data;
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        logic [63:0] bm;
        chk({tag, "/done_cycle"}, 64'(o.cyc), 64'(e.cyc));
        chk({tag, "/fault"}, 64'(o.flt), 64'(e.flt));
        chk({tag, "/cause"}, 64'(o.cause), 64'(e.cause));
        chk({tag, "/load_data"}, o.ld, e.ld);
        chk({tag, "/req_seen"}, 64'(o.vld), 64'(e.vld));
        chk({tag, "/idle_busy"}, 64'(o.ibusy), 64'd0);
        chk({tag, "/idle_fault_hold"}, 64'(o.iflt), 64'(e.flt));
        chk({tag, "/idle_data_hold"}, o.ild, e.ld);
        if (e.vld && o.vld) begin
            bm = '0;
            for (int b = 0; b < 8; b++) if (e.strb[b]) bm[8*b +: 8] = 8'hFF;
            chk({tag, "/req_stable"}, 64'(o.unstable), 64'd0);
            chk({tag, "/req_we"}, 64'(o.we), 64'(e.we));
            chk({tag, "/req_addr"}, 64'(o.raddr), 64'(e.raddr));
            chk({tag, "/req_wstrb"}, 64'(o.strb), 64'(e.strb));
            chk({tag, "/req_wdata"}, o.wdata & bm, e.wdata & bm);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/busy"}, 64'(busy), 64'd0);
        chk({tag, "/done"}, 64'(done), 64'd0);
        chk({tag, "/load_data"}, load_data, 64'd0);
        chk({tag, "/fault"}, 64'(fault), 64'd0);
        chk({tag, "/cause"}, 64'(fault_cause), 64'd0);
        chk({tag, "/req_valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, "/req_we"}, 64'(mem_req_we), 64'd0);
        chk({tag, "/req_addr"}, 64'(mem_req_addr), 64'd0);
        chk({tag, "/req_wdata"}, mem_req_wdata, 64'd0);
        chk({tag, "/req_wstrb"}, 64'(mem_req_wstrb), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        obs_t o;
        obs_t e;
        int   sel;
        int   bytes;

        reset = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 64'd0; store_data = 64'd0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 64'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        //  ld    st    f3      addr          sdata                   rdata                  rdy rsp cyc flt  cause  load_data              vld   we    raddr     wdata                  wstrb
        add(1'b1, 1'b0, 3'b000, 64'h0107, 64'h0,                 64'h80AA_0000_0000_0000, 0,  0,  3, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 64'h020, 64'h0,                 8'h80);
        add(1'b1, 1'b0, 3'b101, 64'h0106, 64'h0,                 64'h8001_0000_0000_0000, 0,  0,  3, 1'b0, 2'b00, 64'h0000_0000_0000_8001, 1'b1, 1'b0, 64'h020, 64'h0,                 8'hC0);
        add(1'b1, 1'b0, 3'b010, 64'h0004, 64'h0,                 64'h8000_0000_0000_0000, 0,  0,  3, 1'b0, 2'b00, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0, 64'h000, 64'h0,                 8'hF0);
        add(1'b0, 1'b1, 3'b010, 64'h0104, 64'hDEADBEEF,          64'h0,                   3,  0,  5, 1'b0, 2'b00, 64'h0,                   1'b1, 1'b1, 64'h020, 64'hDEADBEEF_0000_0000, 8'hF0);
        add(1'b1, 1'b0, 3'b010, 64'h0102, 64'h0,                 64'h0,                   0,  0,  1, 1'b1, 2'b01, 64'h0,                   1'b0, 1'b0, 64'h0,   64'h0,                 8'h00);
        add(1'b1, 1'b0, 3'b011, 64'h2000, 64'h0,                 64'h0,                   0,  0,  1, 1'b1, 2'b10, 64'h0,                   1'b0, 1'b0, 64'h0,   64'h0,                 8'h00);
        add(1'b0, 1'b1, 3'b100, 64'h0010, 64'h55,                64'h0,                   0,  0,  1, 1'b1, 2'b00, 64'h0,                   1'b0, 1'b0, 64'h0,   64'h0,                 8'h00);
        add(1'b1, 1'b0, 3'b011, 64'h0008, 64'h0,                 64'h1234,                0, 99, 17, 1'b1, 2'b11, 64'h0,                   1'b1, 1'b0, 64'h001, 64'h0,                 8'hFF);
        add(1'b1, 1'b0, 3'b011, 64'h0008, 64'h0,                 64'h1122_3344_5566_7788, 0, 14, 17, 1'b0, 2'b00, 64'h1122_3344_5566_7788, 1'b1, 1'b0, 64'h001, 64'h0,                 8'hFF);
        add(1'b1, 1'b1, 3'b000, 64'h0000, 64'h0,                 64'h0,                   0,  0,  1, 1'b1, 2'b00, 64'h0,                   1'b0, 1'b0, 64'h0,   64'h0,                 8'h00);
        add(1'b1, 1'b0, 3'b111, 64'h0000, 64'h0,                 64'h0,                   0,  0,  1, 1'b1, 2'b00, 64'h0,                   1'b0, 1'b0, 64'h0,   64'h0,                 8'h00);
        add(1'b0, 1'b0, 3'b000, 64'h0000, 64'h0,                 64'h0,                   0,  0,  1, 1'b0, 2'b00, 64'h0,                   1'b0, 1'b0, 64'h0,   64'h0,                 8'h00);
        add(1'b0, 1'b1, 3'b011, 64'h1FF8, 64'h0123_4567_89AB_CDEF, 64'h0,                 0,  0,  2, 1'b0, 2'b00, 64'h0,                   1'b1, 1'b1, 64'h3FF, 64'h0123_4567_89AB_CDEF, 8'hFF);
        add(1'b0, 1'b1, 3'b000, 64'h0003, 64'hAB,                64'h0,                   0,  0,  2, 1'b0, 2'b00, 64'h0,                   1'b1, 1'b1, 64'h000, 64'h0000_0000_AB00_0000, 8'h08);
        add(1'b1, 1'b0, 3'b100, 64'h0005, 64'h0,                 64'h0000_9A00_0000_0000, 2,  1,  6, 1'b0, 2'b00, 64'h0000_0000_0000_009A, 1'b1, 1'b0, 64'h000, 64'h0,                 8'h20);
        add(1'b1, 1'b0, 3'b001, 64'h2001, 64'h0,                 64'h0,                   0,  0,  1, 1'b1, 2'b01, 64'h0,                   1'b0, 1'b0, 64'h0,   64'h0,                 8'h00);
        add(1'b0, 1'b1, 3'b001, 64'h2002, 64'h0,                 64'h0,                   0,  0,  1, 1'b1, 2'b10, 64'h0,                   1'b0, 1'b0, 64'h0,   64'h0,                 8'h00);
        add(1'b0, 1'b1, 3'b011, 64'h0040, 64'h77,                64'h0,                  20,  0, 17, 1'b1, 2'b11, 64'h0,                   1'b1, 1'b1, 64'h008, 64'h77,                8'hFF);

        foreach (tbl[i]) begin
            run_op(tbl[i], o);
            compare($sformatf("vec%0d", i), o, tbl[i].e);
        end

        // Reset while waiting for a read response.
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b011; addr = 64'h8; store_data = 64'd0;
        mem_req_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_mid/busy_before", 64'(busy), 64'd1);
        mem_req_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk_all_zero("rst_mid");
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hFFFF_0000_FFFF_0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid/late_rsp_done%0d", k), 64'(done), 64'd0);
        end
        mem_rsp_valid = 1'b0;
        v = tbl[0];
        run_op(v, o);
        compare("rst_mid/recover", o, model(v));

        // start held high with changing fields while a store is in flight.
        is_load = 1'b0; is_store = 1'b1; funct3 = 3'b011; addr = 64'h10;
        store_data = 64'hCAFE_F00D_1234_5678; start = 1'b1;
        @(negedge clk);
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b000; addr = 64'h1238;
        chk("busy_start/addr_c1", 64'(mem_req_addr), 64'h2);
        chk("busy_start/we_c1", 64'(mem_req_we), 64'd1);
        @(negedge clk);
        chk("busy_start/addr_c2", 64'(mem_req_addr), 64'h2);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; start = 1'b0;
        chk("busy_start/done_c3", 64'(done), 64'd1);
        chk("busy_start/fault_c3", 64'(fault), 64'd0);
        @(negedge clk);
        chk("busy_start/idle_c4", 64'(busy), 64'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 250; i++) begin
            sel = int'($urandom_range(0, 19));
            v.ld = (sel == 1) || (sel >= 2 && sel <= 10);
            v.st = (sel == 1) || (sel >= 11);
            if (v.st && !v.ld)
                v.f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            else
                v.f3 = 3'($urandom_range(0, 7));
            bytes = 1 << v.f3[1:0];
            v.a = 64'($urandom_range(0, MEM_BYTES - 1));
            if ($urandom_range(0, 7) != 0) v.a = v.a & ~64'(bytes - 1);
            if ($urandom_range(0, 15) == 0) v.a = v.a | {32'($urandom), 32'd0};
            if (!v.ld && !v.st) v.a = v.a & 64'(MEM_BYTES - 8);
            v.sd  = {$urandom, $urandom};
            v.rd  = {$urandom, $urandom};
            v.rdy = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
            v.rsp = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
            e = model(v);
            run_op(v, o);
            compare($sformatf("rand%0d", i), o, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_requester.md
# lsu_requester

Load/store requester for the sequential core's memory stage. It accepts one load or store per `start` pulse and decodes RISC-V `funct3` into access size and signedness. It checks alignment and range, then drives a valid/ready request to the 64-bit data memory array. It aligns store data into byte lanes, and extracts and sign- or zero-extends load data from the response. The block sits between the execute/memory-stage control and the data memory, and is the initiator end of the data memory port.

## Interface
Parameters:
- `MEM_BYTES`, 8192: data memory size in bytes (power of two, ≥ 8).
- `TIMEOUT_CYCLES`, 16: maximum cycles spent in REQ+RSP before a timeout fault (≥ 2).

Ports (`AW` = log2(`MEM_BYTES`) − 3):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `is_load`  in  1  operation is a load.
- `is_store`  in  1  operation is a store.
- `funct3`  in  3  000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- `addr`  in  64  byte address (ALU result).
- `store_data`  in  64  store value, right-justified.
- `busy`  out  1  high in every state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `load_data`  out  64  extended load result.
- `fault`  out  1  operation aborted.
- `fault_cause`  out  2  00 illegal op, 01 misaligned, 10 out of range, 11 timeout.
- `mem_req_valid`  out  1  request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_we`  out  1  1 = write.
- `mem_req_addr`  out  AW  word index, `addr[AW+2:3]`.
- `mem_req_wdata`  out  64  lane-aligned write data.
- `mem_req_wstrb`  out  8  byte enables; bit i enables byte i.
- `mem_rsp_valid`  in  1  read data valid.
- `mem_rsp_rdata`  in  64  read word.

## Operation
- States: IDLE, REQ, RSP, DONE.
- IDLE accepts `start`. It registers `is_load`, `is_store`, `funct3`, `addr` and `store_data`, and evaluates faults in this priority order:
  - illegal: `is_load` and `is_store` both set, load with `funct3`=111, or store with `funct3[2]`=1;
  - misaligned: `addr` not a multiple of the size (H: bit 0; W: bits 1:0; D: bits 2:0);
  - out of range: `addr` ≥ `MEM_BYTES`.
- Transitions out of IDLE on `start`:
  - any fault → DONE with fault set;
  - neither load nor store → DONE with no fault and `load_data`=0;
  - otherwise → REQ.
- `start` outside IDLE is ignored.
- REQ drives `mem_req_valid`=1. On `mem_req_valid & mem_req_ready`: store → DONE, load → RSP.
- RSP holds `mem_req_valid`=0. On `mem_rsp_valid` it captures the extracted load result → DONE.
- `mem_rsp_valid` is ignored outside RSP.
- DONE asserts `done` for one cycle, then returns to IDLE.
- Size and lane rules, with `off` = `addr[2:0]`:
  - size bytes: B=1, H=2, W=4, D=8;
  - `mem_req_wstrb` = ((1<<size)−1) << off;
  - `mem_req_wdata` = `store_data` << (8·off), truncated to 64 bits; bytes outside the strobe are don't-care;
  - load: `r` = `mem_rsp_rdata` >> (8·off), keep the low `size` bytes, then sign-extend for B/H/W or zero-extend for BU/HU/WU/D (little-endian).
- `mem_req_we`, `mem_req_addr`, `mem_req_wdata` and `mem_req_wstrb` are driven from registered values and stay stable while `mem_req_valid` is high.
- Timeout:
  - counter cleared on entry to REQ, incremented each REQ/RSP cycle without a completion event;
  - when the counter equals `TIMEOUT_CYCLES`−1 with no completion → DONE with fault, `fault_cause`=11, `load_data` unchanged from 0;
  - a completion event in the same cycle wins over the timeout.
- `load_data`, `fault` and `fault_cause` are cleared when a new `start` is accepted. They are set when DONE is entered and held in IDLE until the next accepted `start`.
- Reset (`reset`=0 at an edge), including mid-operation:
  - state IDLE;
  - all outputs 0: `busy`, `done`, `load_data`, `fault`, `fault_cause`, `mem_req_valid`, `mem_req_we`, `mem_req_addr`, `mem_req_wdata`, `mem_req_wstrb`;
  - a later `mem_rsp_valid` is ignored.

## Timing
- Start is accepted at edge 0.
- Store with `mem_req_ready`=1: REQ in cycle 1, DONE (`done`=1) in cycle 2.
- Load with ready and a one-cycle response: REQ in cycle 1, RSP in cycle 2, DONE in cycle 3. `load_data` is valid from cycle 3.
- Fault at start, or neither op: DONE in cycle 1, no memory request issued.
- Each wait cycle on `mem_req_ready` or `mem_rsp_valid` adds one cycle.
- Timeout with `TIMEOUT_CYCLES`=16 and ready never asserted: REQ in cycles 1–16, DONE in cycle 17.
- Back-to-back: the earliest next `start` is accepted in the IDLE cycle after DONE.

## Test plan
- LB at 0x0107, rdata 0x80AA_0000_0000_0000 → req_addr 0x020, we=0; load_data 0xFFFF_FFFF_FFFF_FF80; done in cycle 3.
- LHU at 0x0106, rdata 0x8001_0000_0000_0000 → load_data 0x0000_0000_0000_8001. LW at 0x0004, rdata 0x8000_0000_0000_0000 → load_data 0xFFFF_FFFF_8000_0000.
- SW at 0x0104, store_data 0xDEADBEEF, ready held low 3 cycles → valid held with stable fields; wdata 0xDEADBEEF_0000_0000, wstrb 0xF0, req_addr 0x020; done in cycle 5.
- LW at 0x0102 → fault=1, cause 01, done in cycle 1, mem_req_valid never high. LD at 0x2000 → cause 10. Store with funct3=100 → cause 00.
- LD at 0x0008, ready=1, rsp_valid never → DONE in cycle 17, fault cause 11. Repeat with rsp_valid rising exactly at the timeout cycle → normal completion, no fault.
- Reset pulse during RSP → busy=0 and all outputs 0 the next cycle. A later rsp_valid produces no `done`. A new `start` then completes normally.
